// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared widths, bubble opcode and FSM
// state encoding for the instruction-fetch stage.
package fetch_stage_pkg;

   localparam int          DEF_ADDR_W = 12;
   localparam int          DEF_DATA_W = 8;
   localparam logic [7:0]  DEF_NOP    = 8'h00;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_HOLD = 2'd2,
      S_DROP = 2'd3
   } state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: program-ROM request/acknowledge bus.
// master = fetch side, slave = ROM side.
interface fetch_stage_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8
);

   logic              rom_req;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_rdata;
   logic              rom_ack;

   modport master (
      output rom_req,
      output rom_addr,
      input  rom_rdata,
      input  rom_ack
   );

   modport slave (
      input  rom_req,
      input  rom_addr,
      output rom_rdata,
      output rom_ack
   );

endinterface

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry data register with full flag;
// clear has priority over load, load over unload.
module fetch_skid #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load,
   input  logic         unload,
   input  logic         clear,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full
);

   logic [W-1:0] data_q;
   logic         full_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         data_q <= '0;
         full_q <= 1'b0;
      end else if (clear) begin
         full_q <= 1'b0;
      end else if (load) begin
         data_q <= din;
         full_q <= 1'b1;
      end else if (unload) begin
         full_q <= 1'b0;
      end
   end

   assign dout = data_q;
   assign full = full_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: ROM request/ack fetch into the instruction
// register, with skid hold on stall and NOP bubbles on flush.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int              ADDR_W     = DEF_ADDR_W,
   parameter int              DATA_W     = DEF_DATA_W,
   parameter logic [DATA_W-1:0] NOP_OPCODE = DEF_NOP
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] address,
   input  logic              cflag,
   input  logic              stall,
   input  logic              flush,
   fetch_stage_if.master     rom,
   output logic [DATA_W-1:0] D_BUS,
   output logic              ir_valid,
   output logic              pc_advance,
   output logic              cflag_q
);

   state_t            state, state_n;
   logic [ADDR_W-1:0] addr_q, addr_n;
   logic [DATA_W-1:0] ir_q, ir_n;
   logic              valid_q, valid_n;
   logic              cq_q, cq_n;
   logic              req, adv;
   logic              sk_load, sk_unload, sk_clear;
   logic              sk_full;
   logic [DATA_W-1:0] sk_data;

   fetch_skid #(.W(DATA_W)) u_skid (
      .clock  (clock),
      .reset  (reset),
      .load   (sk_load),
      .unload (sk_unload),
      .clear  (sk_clear),
      .din    (rom.rom_rdata),
      .dout   (sk_data),
      .full   (sk_full)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         addr_q  <= '0;
         ir_q    <= NOP_OPCODE;
         valid_q <= 1'b0;
         cq_q    <= 1'b0;
      end else begin
         state   <= state_n;
         addr_q  <= addr_n;
         ir_q    <= ir_n;
         valid_q <= valid_n;
         cq_q    <= cq_n;
      end
   end

   always_comb begin
      state_n   = state;
      addr_n    = addr_q;
      ir_n      = ir_q;
      valid_n   = valid_q;
      cq_n      = cq_q;
      req       = 1'b0;
      adv       = 1'b0;
      sk_load   = 1'b0;
      sk_unload = 1'b0;
      sk_clear  = 1'b0;
      unique case (state)
         S_IDLE: begin
            state_n = S_REQ;
            addr_n  = address;
         end
         S_REQ: begin
            req = 1'b1;
            if (rom.rom_ack) begin
               if (flush) begin
                  addr_n = address;
               end else if (stall) begin
                  sk_load = 1'b1;
                  adv     = 1'b1;
                  state_n = S_HOLD;
               end else begin
                  ir_n    = rom.rom_rdata;
                  valid_n = 1'b1;
                  cq_n    = cflag;
                  adv     = 1'b1;
                  addr_n  = address;
               end
            end else if (flush) begin
               state_n = S_DROP;
            end
         end
         S_HOLD: begin
            if (flush) begin
               sk_clear = 1'b1;
               state_n  = S_REQ;
               addr_n   = address;
            end else if (!stall) begin
               ir_n      = sk_full ? sk_data : NOP_OPCODE;
               valid_n   = sk_full;
               cq_n      = cflag;
               sk_unload = 1'b1;
               state_n   = S_REQ;
               addr_n    = address;
            end
         end
         S_DROP: begin
            // ROM reads cannot be aborted; wait out the ack.
            req = 1'b1;
            if (rom.rom_ack) begin
               state_n = S_REQ;
               addr_n  = address;
            end
         end
         default: state_n = S_IDLE;
      endcase
      if (flush) begin
         ir_n    = NOP_OPCODE;
         valid_n = 1'b0;
         cq_n    = cflag;
      end
   end

   assign rom.rom_req  = req;
   assign rom.rom_addr = addr_q;
   assign D_BUS        = ir_q;
   assign ir_valid     = valid_q;
   assign pc_advance   = adv;
   assign cflag_q      = cq_q;

endmodule
